// File: rtl/pc_pkg.sv
// Shared op-code encoding and error-vector bit positions for the program-counter unit.
// Codes 6 and 7 are left unassigned and decode as HOLD.
package pc_pkg;

  localparam logic [2:0] OP_HOLD   = 3'd0;
  localparam logic [2:0] OP_INC    = 3'd1;
  localparam logic [2:0] OP_LOAD   = 3'd2;
  localparam logic [2:0] OP_BRANCH = 3'd3;
  localparam logic [2:0] OP_CALL   = 3'd4;
  localparam logic [2:0] OP_RET    = 3'd5;

  localparam int ERR_OVF_BIT = 0;
  localparam int ERR_UNF_BIT = 1;

endpackage

// File: rtl/pc_stack.sv
// Return-address LIFO: registered storage and depth, combinational read of the top entry.
// Push takes effect on the next edge; push when full and pop when empty are ignored.
module pc_stack #(
  parameter int DEPTH = 8,
  parameter int W     = 16,
  parameter int SP_W  = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic [W-1:0]    push_dat,
  output logic [W-1:0]    top_dat,
  output logic [SP_W-1:0] sp,
  output logic            full,
  output logic            empty
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]    mem_q [DEPTH];
  logic [SP_W-1:0] sp_q, sp_d;
  logic [IDX_W-1:0] top_idx, wr_idx;
  logic            do_push, do_pop;

  assign full    = (sp_q == SP_W'(DEPTH));
  assign empty   = (sp_q == '0);
  assign sp      = sp_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign wr_idx  = IDX_W'(sp_q);
  assign top_idx = IDX_W'(sp_q - 1'b1);
  assign top_dat = mem_q[top_idx];

  always_comb begin
    sp_d = sp_q;
    if (do_push)     sp_d = sp_q + 1'b1;
    else if (do_pop) sp_d = sp_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sp_q <= '0;
    else        sp_q <= sp_d;
  end

  // Contents are don't-care beyond sp, so storage carries no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_idx] <= push_dat;
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter with relative branch, call/return over an internal stack and sticky stack errors.
// Results visible one edge after op is sampled; stall freezes everything except err_clr.
module pc_unit
  import pc_pkg::*;
#(
  parameter int                ADDR_W      = 16,
  parameter int                OFF_W       = 8,
  parameter int                STACK_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_VEC   = '0,
  localparam int               SP_W        = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] target,
  input  logic [OFF_W-1:0]  offset,
  input  logic              err_clr,
  output logic [ADDR_W-1:0] pc,
  output logic [SP_W-1:0]   sp,
  output logic              stack_full,
  output logic              stack_empty,
  output logic              ovf_err,
  output logic              unf_err
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic [ADDR_W-1:0] pc_inc, pc_br, top_dat;
  logic              push, pop, full, empty;

  assign pc_inc = pc_q + 1'b1;
  assign pc_br  = pc_q + ADDR_W'($signed(offset));

  pc_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (ADDR_W),
    .SP_W  (SP_W)
  ) u_stack (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pop      (pop),
    .push_dat (pc_inc),
    .top_dat  (top_dat),
    .sp       (sp),
    .full     (full),
    .empty    (empty)
  );

  always_comb begin
    pc_d  = pc_q;
    push  = 1'b0;
    pop   = 1'b0;
    ovf_d = err_clr ? 1'b0 : ovf_q;
    unf_d = err_clr ? 1'b0 : unf_q;
    if (!stall) begin
      case (op)
        OP_INC:    pc_d = pc_inc;
        OP_LOAD:   pc_d = target;
        OP_BRANCH: pc_d = pc_br;
        OP_CALL: begin
          if (full) begin
            ovf_d = 1'b1;
          end else begin
            push = 1'b1;
            pc_d = target;
          end
        end
        OP_RET: begin
          if (empty) begin
            unf_d = 1'b1;
          end else begin
            pop  = 1'b1;
            pc_d = top_dat;
          end
        end
        default: pc_d = pc_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_VEC;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign pc          = pc_q;
  assign stack_full  = full;
  assign stack_empty = empty;
  assign ovf_err     = ovf_q;
  assign unf_err     = unf_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit with default parameters; expected values are hand-computed.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic [2:0]  op;
  logic [15:0] target;
  logic [7:0]  offset;
  logic        err_clr;
  logic [15:0] pc;
  logic [3:0]  sp;
  logic        stack_full, stack_empty, ovf_err, unf_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .op          (op),
    .target      (target),
    .offset      (offset),
    .err_clr     (err_clr),
    .pc          (pc),
    .sp          (sp),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .ovf_err     (ovf_err),
    .unf_err     (unf_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [2:0] o, input logic [15:0] t, input logic [7:0] f);
    op = o; target = t; offset = f;
    @(posedge clk);
    #1;
    op = 3'd0;
  endtask

  task automatic check_state(input string tag, input logic [15:0] e_pc, input logic [3:0] e_sp);
    check({tag, ".pc"}, 32'(pc), 32'(e_pc));
    check({tag, ".sp"}, 32'(sp), 32'(e_sp));
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; op = 3'd0; target = '0; offset = '0; err_clr = 1'b0;
    #12;
    check_state("reset", 16'h0000, 4'd0);
    check("reset.empty", 32'(stack_empty), 32'd1);
    check("reset.full", 32'(stack_full), 32'd0);
    check("reset.ovf", 32'(ovf_err), 32'd0);
    check("reset.unf", 32'(unf_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    step(3'd1, 16'h0, 8'h0); check_state("inc1", 16'h0001, 4'd0);
    step(3'd1, 16'h0, 8'h0); check_state("inc2", 16'h0002, 4'd0);
    step(3'd1, 16'h0, 8'h0); check_state("inc3", 16'h0003, 4'd0);
    check("inc.empty", 32'(stack_empty), 32'd1);

    step(3'd2, 16'h1234, 8'h00); check_state("load", 16'h1234, 4'd0);
    step(3'd3, 16'h0000, 8'h80); check_state("br_neg", 16'h11B4, 4'd0);
    step(3'd3, 16'h0000, 8'h7F); check_state("br_pos", 16'h1233, 4'd0);
    step(3'd2, 16'hFFFF, 8'h00); check_state("load_max", 16'hFFFF, 4'd0);
    step(3'd1, 16'h0000, 8'h00); check_state("inc_wrap", 16'h0000, 4'd0);
    step(3'd6, 16'h5555, 8'h11); check_state("rsvd6", 16'h0000, 4'd0);
    step(3'd7, 16'h5555, 8'h11); check_state("rsvd7", 16'h0000, 4'd0);

    step(3'd2, 16'h0100, 8'h00);
    step(3'd4, 16'h2000, 8'h00); check_state("call1", 16'h2000, 4'd1);
    step(3'd4, 16'h3000, 8'h00); check_state("call2", 16'h3000, 4'd2);
    step(3'd5, 16'h0000, 8'h00); check_state("ret1", 16'h2001, 4'd1);
    step(3'd5, 16'h0000, 8'h00); check_state("ret2", 16'h0101, 4'd0);
    check("ret2.empty", 32'(stack_empty), 32'd1);
    step(3'd5, 16'h0000, 8'h00); check_state("ret_unf", 16'h0101, 4'd0);
    check("ret_unf.unf", 32'(unf_err), 32'd1);
    check("ret_unf.ovf", 32'(ovf_err), 32'd0);

    // Fill the stack: each call pushes pc+1 and jumps to 1000h + k*100h.
    step(3'd2, 16'h0000, 8'h00);
    for (int k = 0; k < 8; k++) step(3'd4, 16'h1000 + 16'(k * 16'h0100), 8'h00);
    check_state("fill", 16'h1700, 4'd8);
    check("fill.full", 32'(stack_full), 32'd1);
    check("fill.ovf", 32'(ovf_err), 32'd0);
    step(3'd4, 16'h9000, 8'h00); check_state("call9", 16'h1700, 4'd8);
    check("call9.ovf", 32'(ovf_err), 32'd1);

    err_clr = 1'b1;
    step(3'd4, 16'h9000, 8'h00);
    check("clr_vs_set.ovf", 32'(ovf_err), 32'd1);
    check("clr_vs_set.unf", 32'(unf_err), 32'd0);
    step(3'd0, 16'h0000, 8'h00);
    err_clr = 1'b0;
    check("clr.ovf", 32'(ovf_err), 32'd0);
    check("clr.unf", 32'(unf_err), 32'd0);

    step(3'd5, 16'h0000, 8'h00); check_state("ret_full", 16'h1601, 4'd7);
    check("ret_full.full", 32'(stack_full), 32'd0);

    stall = 1'b1;
    step(3'd4, 16'h4000, 8'h00); check_state("stall", 16'h1601, 4'd7);
    check("stall.ovf", 32'(ovf_err), 32'd0);
    stall = 1'b0;
    step(3'd4, 16'h4000, 8'h00); check_state("unstall", 16'h4000, 4'd8);
    step(3'd5, 16'h0000, 8'h00); check_state("b2b_ret", 16'h1602, 4'd7);

    step(3'd5, 16'h0000, 8'h00); check_state("pop_a", 16'h1501, 4'd6);
    step(3'd5, 16'h0000, 8'h00); check_state("pop_b", 16'h1401, 4'd5);
    step(3'd5, 16'h0000, 8'h00); check_state("pop_c", 16'h1301, 4'd4);
    step(3'd5, 16'h0000, 8'h00); check_state("pop_d", 16'h1201, 4'd3);
    step(3'd2, 16'h2345, 8'h00); check_state("pre_rst", 16'h2345, 4'd3);

    #3;
    rst_n = 1'b0;
    #1;
    check_state("async_rst", 16'h0000, 4'd0);
    check("async_rst.empty", 32'(stack_empty), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step(3'd5, 16'h0000, 8'h00); check_state("post_rst_ret", 16'h0000, 4'd0);
    check("post_rst_ret.unf", 32'(unf_err), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
